amp_offset_cal_ctrl: RTL
========================

// Module: amp_offset_cal_ctrl
// PURPOSE
//  Multi-channel offset-calibration sequencer for the self-biased diff-amp array.
//  - Runs a SAR binary search per channel on a TRIM_W-bit offset-trim DAC code,
//    reading the shared latched comparator on the amp output.
//  - Holds the final codes for the analog macro.
//  - Sits between the digital config block and the amp/trim-DAC macros.
//
// PARAMETERS
//  NUM_CH      4   number of amplifier channels, calibrated sequentially (>=1)
//  TRIM_W      6   trim code width per channel (>=2)
//  SETTLE_CYC  16  wait cycles after any trim/channel change before sampling (>=2)
//  localparam CH_W = (NUM_CH>1) ? $clog2(NUM_CH) : 1
//
// PORTS
//  clk      in   1              system clock
//  rst      in   1              async active-high reset
//  start    in   1              1-cycle pulse; begins calibration of all channels
//  abort    in   1              level; stops the sweep, returns to IDLE
//  comp_in  in   1              raw async comparator: 1 = amp out above threshold
//  cal_mode out  1              shorts the amp inputs (a=b) while busy
//  ch_idx   out  CH_W           channel currently routed to the comparator
//  trim_o   out  NUM_CH*TRIM_W  trim codes, channel k at [k*TRIM_W +: TRIM_W]
//  busy     out  1              high from the cycle after start until DONE/IDLE
//  done     out  1              1-cycle pulse when all channels have finished
//  sat      out  NUM_CH         final code of channel k is all-0 or all-1
//
// BEHAVIOUR
//  Reset (async, rst=1): IDLE, busy=0, done=0, cal_mode=0, ch_idx=0, sat=0.
//    Every trim field is set to mid-code 1<<(TRIM_W-1). Synchroniser is cleared.
//  comp_in passes through a 2-flop synchroniser; SETTLE_CYC>=2 absorbs its latency.
//  FSM: IDLE -> CH_SETTLE -> BIT_SET -> BIT_SETTLE -> SAMPLE -> (BIT_SET | NEXT_CH) -> DONE -> IDLE
//   IDLE:       start=1 -> CH_SETTLE, ch_idx=0, bit=TRIM_W-1, cal_mode=1, busy=1.
//   CH_SETTLE:  clears trim[ch_idx] to 0; waits SETTLE_CYC cycles.
//   BIT_SET:    1 cycle; sets trim[ch_idx][bit]=1.
//   BIT_SETTLE: SETTLE_CYC cycles.
//   SAMPLE:     1 cycle; sync comp=1 clears trim[ch_idx][bit]. If bit>0: bit--, go BIT_SET.
//   NEXT_CH:    1 cycle; updates sat[ch_idx]. If last channel -> DONE,
//               else ch_idx++ and bit reset -> CH_SETTLE.
//   DONE:       1 cycle; done=1, cal_mode=0, busy=0 on exit -> IDLE.
//  Latency per channel = SETTLE_CYC + TRIM_W*(SETTLE_CYC+2) + 1 cycles.
//  start while busy: ignored. start and abort in the same cycle: abort wins (stay IDLE).
//  abort in any non-IDLE state: next cycle -> IDLE.
//    busy=0, cal_mode=0, no done pulse.
//    trim[ch_idx] restored to mid-code; finished channels keep their codes.
//    sat bits of finished channels are kept.
//  A new start clears all sat bits. Channels already finished keep their codes until recalibrated.
//  Outputs are registered; trim_o never glitches within a cycle.
//
// CONFIGURATION
//  AMP_CAL_MAJORITY_EN defined:
//    - SAMPLE lasts 3 cycles and takes a 2-of-3 majority of the synced comparator.
//    - Per-bit cost becomes SETTLE_CYC+4.
//  Undefined: single-sample SAMPLE as above; no vote logic is instantiated.
//
// STRUCTURE
//  Package amp_cal_pkg:
//    - state enum (IDLE, CH_SETTLE, BIT_SET, BIT_SETTLE, SAMPLE, NEXT_CH, DONE)
//    - function mid_code(TRIM_W)
//    - settle-counter width rule
//  Sub-module amp_cal_sampler: 2-flop synchroniser plus (under the macro) 3-sample
//    majority voter; outputs comp_bit and comp_valid.
//
// TESTING  (NUM_CH=2, TRIM_W=4, SETTLE_CYC=4, comparator model comp=(trim[ch]>target[ch]))
//  1. Reset -> trim_o=8'h88, busy=0, done=0, sat=0, cal_mode=0.
//  2. Targets {ch0=5, ch1=10}, start -> trim_o=8'hA5, sat=0.
//     done pulses exactly 2*(4+4*6+1)=58 cycles after BIT sequence entry (check cycle count).
//  3. Targets {15, 0} -> trim codes 15 and 0, sat=2'b11.
//  4. abort during ch1 BIT_SETTLE -> next cycle busy=0 and trim ch1=8.
//     ch0 keeps its calibrated code; no done pulse.
//  5. start re-pulsed mid-run -> no restart; final codes and done timing are identical to scenario 2.
//  6. rst asserted mid-run (async, between clock edges) -> all outputs hit reset values immediately.
//     With AMP_CAL_MAJORITY_EN, a single-cycle comp glitch in SAMPLE does not flip a bit.

Source files
------------

// File: rtl/amp_cal_pkg.sv
// Shared types and helpers for the amplifier offset-calibration sequencer.
package amp_cal_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CH_SETTLE,
        BIT_SET,
        BIT_SETTLE,
        SAMPLE,
        NEXT_CH,
        DONE
    } cal_state_t;

    // Mid-scale trim code, used as the neutral value outside calibration.
    function automatic logic [31:0] mid_code(input int trim_w);
        return 32'd1 << (trim_w - 1);
    endfunction

    // Settle counter runs 0..settle_cyc-1.
    function automatic int settle_cnt_w(input int settle_cyc);
        return (settle_cyc > 2) ? $clog2(settle_cyc) : 1;
    endfunction

endpackage

// File: rtl/amp_cal_sampler.sv
// Comparator synchroniser; AMP_CAL_MAJORITY_EN adds a 2-of-3 vote over three samples.
module amp_cal_sampler (
    input  logic clk,
    input  logic rst,
    input  logic comp_in,
    input  logic sample_en,
    output logic comp_bit,
    output logic comp_valid
);

    logic comp_s1;
    logic comp_s2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            comp_s1 <= 1'b0;
            comp_s2 <= 1'b0;
        end else begin
            comp_s1 <= comp_in;
            comp_s2 <= comp_s1;
        end
    end

`ifdef AMP_CAL_MAJORITY_EN
    logic [1:0] hist;
    logic [1:0] n_smp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist  <= 2'b00;
            n_smp <= 2'd0;
        end else if (!sample_en) begin
            n_smp <= 2'd0;
        end else begin
            hist  <= {hist[0], comp_s2};
            n_smp <= (n_smp == 2'd2) ? 2'd0 : n_smp + 2'd1;
        end
    end

    // Third sample is combined live so the decision lands on the last SAMPLE cycle.
    assign comp_valid = sample_en && (n_smp == 2'd2);
    assign comp_bit   = (hist[1] & hist[0]) | (hist[1] & comp_s2) | (hist[0] & comp_s2);
`else
    assign comp_valid = sample_en;
    assign comp_bit   = comp_s2;
`endif

endmodule

// File: rtl/amp_offset_cal_ctrl.sv
// Sequential per-channel SAR offset calibration for the diff-amp array.
// Optional feature macro: AMP_CAL_MAJORITY_EN (3-sample majority comparator read).
module amp_offset_cal_ctrl
    import amp_cal_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int TRIM_W     = 6,
    parameter int SETTLE_CYC = 16,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     comp_in,
    output logic                     cal_mode,
    output logic [CH_W-1:0]          ch_idx,
    output logic [NUM_CH*TRIM_W-1:0] trim_o,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_CH-1:0]        sat
);

    localparam int CNT_W = settle_cnt_w(SETTLE_CYC);
    localparam int BIT_W = (TRIM_W > 2) ? $clog2(TRIM_W) : 1;
    localparam logic [TRIM_W-1:0] MID         = TRIM_W'(mid_code(TRIM_W));
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CH_W-1:0]   LAST_CH     = CH_W'(NUM_CH - 1);
    localparam logic [BIT_W-1:0]  TOP_BIT     = BIT_W'(TRIM_W - 1);

    cal_state_t        state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic [BIT_W-1:0]  bit_idx;
    logic [TRIM_W-1:0] trim_q [NUM_CH];
    logic              comp_bit;
    logic              comp_valid;

    amp_cal_sampler u_sampler (
        .clk        (clk),
        .rst        (rst),
        .comp_in    (comp_in),
        .sample_en  (state == SAMPLE),
        .comp_bit   (comp_bit),
        .comp_valid (comp_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (state != IDLE && abort) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:       if (start && !abort) state_nx = CH_SETTLE;
                CH_SETTLE:  if (cnt == SETTLE_LAST) state_nx = BIT_SET;
                BIT_SET:    state_nx = BIT_SETTLE;
                BIT_SETTLE: if (cnt == SETTLE_LAST) state_nx = SAMPLE;
                SAMPLE:     if (comp_valid) state_nx = (bit_idx == '0) ? NEXT_CH : BIT_SET;
                NEXT_CH:    state_nx = (ch_idx == LAST_CH) ? DONE : CH_SETTLE;
                DONE:       state_nx = IDLE;
                default:    state_nx = IDLE;
            endcase
        end
    end

    // Outputs follow the next state so every port comes straight from a flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt      <= '0;
            bit_idx  <= TOP_BIT;
            ch_idx   <= '0;
            sat      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            cal_mode <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) trim_q[k] <= MID;
        end else begin
            busy     <= (state_nx != IDLE);
            cal_mode <= (state_nx != IDLE) && (state_nx != DONE);
            done     <= (state_nx == DONE);
            cnt      <= ((state == CH_SETTLE || state == BIT_SETTLE) && state_nx == state)
                        ? cnt + 1'b1 : '0;

            if (abort && state != IDLE) begin
                if (state != DONE) trim_q[ch_idx] <= MID;
            end else begin
                case (state)
                    IDLE: if (state_nx == CH_SETTLE) begin
                        ch_idx    <= '0;
                        bit_idx   <= TOP_BIT;
                        sat       <= '0;
                        trim_q[0] <= '0;
                    end
                    BIT_SET: trim_q[ch_idx][bit_idx] <= 1'b1;
                    SAMPLE: if (comp_valid) begin
                        if (comp_bit) trim_q[ch_idx][bit_idx] <= 1'b0;
                        if (bit_idx != '0) bit_idx <= bit_idx - 1'b1;
                    end
                    NEXT_CH: begin
                        sat[ch_idx] <= (&trim_q[ch_idx]) | ~(|trim_q[ch_idx]);
                        if (ch_idx != LAST_CH) begin
                            ch_idx                 <= ch_idx + 1'b1;
                            bit_idx                <= TOP_BIT;
                            trim_q[ch_idx + 1'b1]  <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    for (genvar k = 0; k < NUM_CH; k++) begin : g_trim
        assign trim_o[k*TRIM_W +: TRIM_W] = trim_q[k];
    end

endmodule
